// File: rtl/mux4_arb_pkg.sv
// Shared types and sizing helpers for the 4-requester round-robin packet arbiter.
package mux4_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Beat counter must be able to hold MAX_BEATS itself.
    function automatic int cnt_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester at or after ptr, scanning upward mod 4.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        any  = |req;
        idx  = ptr;
        cand = '0;
        // Descending scan so the closest candidate to ptr is written last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin packet arbiter sequencing a shared 4:1 data mux; grant is held until last or watchdog.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] in_data,
    input  logic [N_REQ-1:0]        in_last,
    output logic [N_REQ-1:0]        in_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        sel,
    output logic [N_REQ-1:0]        gnt,
    output logic                    busy,
    output logic                    err,
    output arb_state_t              dbg_state,
    output logic [SEL_W-1:0]        dbg_ptr
);

    localparam int CNT_W = cnt_width(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

    // Handshake: a beat transfers when out_valid and out_ready are both high in GRANT;
    // in_ready[sel] mirrors out_ready so the source sees exactly the sink's acceptance.

    arb_state_t       state, state_n;
    logic [SEL_W-1:0] sel_n, ptr, ptr_n;
    logic [N_REQ-1:0] gnt_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             err_n;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             granted, beat, wd_hit, rel;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign granted = (state == GRANT);
    assign beat    = granted & req[sel] & out_ready;
    assign cnt_inc = cnt + 1'b1;
    assign wd_hit  = (cnt_inc == CNT_MAX);
    assign rel     = beat & (in_last[sel] | wd_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            gnt   <= '0;
            ptr   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            gnt   <= gnt_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        gnt_n   = gnt;
        ptr_n   = ptr;
        cnt_n   = cnt;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n = GRANT;
                    sel_n   = pick_idx;
                    gnt_n   = N_REQ'(1) << pick_idx;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (beat) begin
                    cnt_n = cnt_inc;
                end
                if (rel) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = sel + 1'b1;
                    cnt_n   = '0;
                    // A watchdog release that happens to carry last is still a clean packet end.
                    err_n   = ~in_last[sel];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        out_data  = in_data[sel*DATA_W +: DATA_W];
        out_valid = granted & req[sel];
        out_last  = granted & in_last[sel];
        in_ready  = '0;
        if (granted && out_ready) begin
            in_ready[sel] = 1'b1;
        end
        busy      = granted;
        dbg_state = state;
        dbg_ptr   = ptr;
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed plus randomized bench for mux4_rr_arbiter against a packet-level reference model.
module tb_mux4_rr_arbiter;
    import mux4_arb_pkg::*;

    localparam int DATA_W = 4;
    localparam int MAXB   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]        in_last;
    logic [3:0]        in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic [1:0]        sel;
    logic [3:0]        gnt;
    logic              busy;
    logic              err;
    arb_state_t        dbg_state;
    logic [1:0]        dbg_ptr;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model state: who owns the mux, beats so far, next scan start.
    bit m_busy;
    int m_sel, m_ptr, m_cnt;
    bit m_err;

    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];

    mux4_rr_arbiter #(.DATA_W(DATA_W), .MAX_BEATS(MAXB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt       (gnt),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_sel  = 0;
        m_ptr  = 0;
        m_cnt  = 0;
        m_err  = 0;
    endtask

    task automatic model_update(input logic [3:0] r, input logic [3:0] l, input logic o);
        m_err = 0;
        if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (r[c]) begin
                    m_sel  = c;
                    m_busy = 1;
                    m_cnt  = 0;
                    break;
                end
            end
        end else if (r[m_sel] && o) begin
            m_cnt++;
            if (l[m_sel] || m_cnt == MAXB) begin
                m_err  = !l[m_sel];
                m_busy = 0;
                m_ptr  = (m_sel + 1) % 4;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [3:0] e_gnt, e_rdy;
        logic [DATA_W-1:0] e_data;
        e_gnt  = m_busy ? (4'b0001 << m_sel) : 4'b0000;
        e_rdy  = (m_busy && out_ready) ? (4'b0001 << m_sel) : 4'b0000;
        e_data = DATA_W'(in_data >> (m_sel * DATA_W));
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("state", 32'(dbg_state), 32'(m_busy ? GRANT : IDLE));
        chk("ptr", 32'(dbg_ptr), 32'(m_ptr));
        chk("err", 32'(err), 32'(m_err));
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_busy && req[m_sel]));
        chk("out_last", 32'(out_last), 32'(m_busy && in_last[m_sel]));
        chk("out_data", 32'(out_data), 32'(e_data));
    endtask

    // One clock: drive at the falling edge, check mid-cycle, advance model at the rising edge.
    task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic o);
        req       = r;
        in_last   = l;
        out_ready = o;
        in_data   = 16'($urandom);
        #1;
        check_outputs();
        @(posedge clk);
        model_update(r, l, o);
        @(negedge clk);
    endtask

    task automatic check_reset_values();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h0);
        chk("rst_last", 32'(out_last), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_data", 32'(out_data), 32'(in_data[DATA_W-1:0]));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = 4'($urandom);
        in_last   = 4'($urandom);
        out_ready = 1'($urandom);
        in_data   = 16'($urandom);
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        req       = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset with random inputs
        do_reset();
        cycle(4'b0000, 4'b0000, 1'b1);

        // Single packet from requester 2, three beats
        cycle(4'b0100, 4'b0000, 1'b1);
        chk("sp_gnt", 32'(gnt), 32'h4);
        chk("sp_sel", 32'(sel), 32'h2);
        cycle(4'b0100, 4'b0000, 1'b1);
        cycle(4'b0100, 4'b0000, 1'b1);
        cycle(4'b0100, 4'b0100, 1'b1);
        chk("sp_idle", 32'(busy), 32'h0);
        chk("sp_ptr", 32'(dbg_ptr), 32'h3);

        // Round robin under full load, one-beat packets
        do_reset();
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        got_q.delete();
        for (int i = 0; i < 10; i++) begin
            cycle(4'b1111, 4'b1111, 1'b1);
            if (busy) got_q.push_back(sel);
        end
        chk("rr_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk("rr_order", 32'(got_q[i]), 32'(exp_q[i]));
        end
        cycle(4'b1111, 4'b1111, 1'b1);
        chk("rr_from_ptr1", 32'(sel), 32'h1);
        cycle(4'b1111, 4'b1111, 1'b1);

        // Backpressure mid-packet
        cycle(4'b0010, 4'b0000, 1'b1);
        cycle(4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0010, 4'b0000, 1'b0);
            chk("bp_hold", 32'(busy), 32'h1);
        end
        cycle(4'b0010, 4'b0010, 1'b1);
        chk("bp_done", 32'(busy), 32'h0);

        // Watchdog release without last
        do_reset();
        cycle(4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) cycle(4'b0010, 4'b0000, 1'b1);
        chk("wd_err", 32'(err), 32'h1);
        chk("wd_ptr", 32'(dbg_ptr), 32'h2);
        cycle(4'b0000, 4'b0000, 1'b1);
        chk("wd_err_pulse", 32'(err), 32'h0);

        // Last on the fourth beat is a clean release
        cycle(4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) cycle(4'b0010, 4'b0000, 1'b1);
        cycle(4'b0010, 4'b0010, 1'b1);
        chk("wd_last_idle", 32'(busy), 32'h0);
        chk("wd_last_err", 32'(err), 32'h0);

        // Bubble, then asynchronous reset mid-packet
        cycle(4'b0010, 4'b0000, 1'b1);
        cycle(4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cycle(4'b0000, 4'b0000, 1'b1);
            chk("bub_valid", 32'(out_valid), 32'h0);
            chk("bub_hold", 32'(gnt), 32'h2);
        end
        req       = 4'b0010;
        out_ready = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(4'b1111, 4'b0000, 1'b1);
        chk("post_rst_sel", 32'(sel), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] r, l;
            logic o;
            r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            l = 4'($urandom) & 4'($urandom);
            o = ($urandom_range(0, 3) != 0);
            cycle(r, l, o);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

- Round-robin packet arbiter that shares one 4:1 data mux between four requesters.
- Issues the 2-bit mux select and a one-hot grant, and holds each grant for a whole packet (ends on `last`).
- Passes valid/ready handshakes through the selected path.
- Sits between four upstream packet sources and one downstream sink. It is the sequencer for the team's 4-to-1 mux datapath.

## Interface
Parameters:
- DATA_W, 4, width of each requester's data word
- MAX_BEATS, 16, watchdog limit: maximum beats per grant before forced release (≥1)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- req  in  4  per-requester valid (requester i owns bit i)
- in_data  in  4*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
- in_last  in  4  per-requester end-of-packet flag, qualified by req
- in_ready  out  4  per-requester ready; at most one bit high
- out_data  out  DATA_W  muxed data
- out_valid  out  1  muxed valid
- out_last  out  1  muxed last
- out_ready  in  1  downstream ready
- sel  out  2  registered mux select, index of the granted requester
- gnt  out  4  registered one-hot grant; 0 when idle
- busy  out  1  high while a grant is held
- err  out  1  one-cycle pulse on watchdog forced release

## Operation
- States: IDLE, GRANT. Registers: state, sel, gnt, rr pointer ptr[1:0], beat counter cnt (width clog2(MAX_BEATS+1)), err.
- Reset values: state=IDLE, ptr=0, sel=0, gnt=0, cnt=0, err=0. Consequently busy=0, out_valid=0, in_ready=0, out_last=0 and out_data=in_data[0 slice].
- **IDLE** with any req bit set:
  - Pick the first i with req[i]=1, scanning ptr, ptr+1, … (mod 4).
  - Next cycle: sel=i, gnt=1<<i, state=GRANT, cnt=0.
- **IDLE** with req=0: hold all registers.
- **GRANT** datapath (combinational):
  - out_data=in_data[sel], out_valid=req[sel], out_last=in_last[sel].
  - in_ready[sel]=out_ready; all other in_ready bits are 0.
  - Non-granted requesters never see ready.
- Beat definition: req[sel] & out_ready in GRANT. Each beat increments cnt.
- Release condition: a beat with in_last[sel]=1, or a beat that makes cnt reach MAX_BEATS. On the following edge:
  - state=IDLE, gnt=0, ptr=sel+1 (wraps 3→0), cnt=0.
  - sel keeps its last value.
- Watchdog release without last: err=1 for exactly one cycle. A beat carrying last on the MAX_BEATS-th beat is a normal release with err=0.
- Granted requester drops req mid-packet: the grant is held, out_valid=0, no beat, cnt unchanged.
- out_ready low: no beat; in_ready[sel]=0 and the requester must hold data.
- Other requesters asserting req during GRANT are ignored until IDLE.

## Timing
- Arbitration latency: req sampled high in IDLE at edge N → gnt/sel/busy valid after edge N; first beat possible in cycle N+1.
- Datapath is zero-latency combinational from the granted input to the output. There is no data register in the block.
- Exactly one dead IDLE cycle between consecutive grants, even under continuous requests.
- Fairness: under all-requesters-active load, every requester is granted once per 4 grants.
- Asynchronous reset mid-packet: outputs drop to reset values immediately, without waiting for a clock. The in-flight packet is truncated and the downstream must discard it.

## Structure
- Package mux4_arb_pkg holds:
  - N_REQ=4 and SEL_W=2
  - the state enum (IDLE, GRANT)
  - the function/constant for cnt width
- Sub-module rr_pick4: purely combinational. Inputs req[3:0] and ptr[1:0]; outputs any and idx[1:0]. Instantiated once. The top holds the FSM, counters and output mux.

## Test plan
- Reset: assert rst with random inputs → gnt=0, sel=0, busy=0, out_valid=0, in_ready=0, err=0. Async: outputs clear before the next clk edge.
- Single packet: req[2]=1 for 3 beats, last on the 3rd, out_ready=1 →
  - gnt=4'b0100 and sel=2 after edge 1
  - beats in cycles 1–3
  - IDLE in cycle 4
  - ptr=3
- Round-robin: req=4'b1111, every beat last, out_ready=1 → grants in order 0,1,2,3,0, each lasting 2 cycles (grant + dead cycle). After the start-from-ptr=1 case, the first grant goes to 1.
- Backpressure: out_ready=0 for 3 cycles mid-packet → in_ready[sel]=0, cnt frozen, no release. The packet completes after out_ready returns.
- Watchdog: MAX_BEATS=4, requester 1 streams without last → release after the 4th beat, err high for exactly one cycle, ptr=2. Repeat with last on the 4th beat → err=0.
- Bubble and reset: the granted requester drops req for 2 cycles → out_valid=0 and the grant is held. Then assert rst mid-packet → immediate return to reset values, and the next arbitration starts from ptr=0.
